// File: rtl/mux2_sampler_pkg.sv
// rtl/mux2_sampler_pkg.sv - shared types and defaults for the mux2 sampler
package mux2_sampler_pkg;

  localparam int DEFAULT_SETTLE_CYCLES = 2;

  typedef logic chan_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter that flags the last settle cycle
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             done
);

  // Counting stops at zero so an idle timer never raises done spuriously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - CNT_W'(1);
    end
  end

  assign done = (value == CNT_W'(1));

endmodule

// File: rtl/mux2_sampler.sv
// rtl/mux2_sampler.sv - arbitrates two requesters, settles mux sel, samples z (MUX2_SAMPLER_RR_EN: round-robin ties)
module mux2_sampler
  import mux2_sampler_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic ack0,
  output logic ack1,
  output logic sel,
  input  logic z,
  output logic dout,
  output logic dout_ch,
  output logic dout_valid,
  input  logic dout_ready
);

  state_t           state;
  chan_t            grant;
  logic             load;
  logic             timer_done;
  logic [CNT_W-1:0] cnt_value;

  assign load = (state == IDLE) && (req0 || req1);

`ifdef MUX2_SAMPLER_RR_EN
  chan_t last_grant;

  // On a tie the channel that did not win last time gets the mux.
  assign grant = req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (load) begin
      last_grant <= grant;
    end
  end
`else
  assign grant = req1 & ~req0;
`endif

  settle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .value    (cnt_value),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 1'b0;
      dout       <= 1'b0;
      dout_ch    <= 1'b0;
      dout_valid <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            sel   <= grant;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (timer_done) begin
            dout       <= z;
            dout_ch    <= sel;
            dout_valid <= 1'b1;
            ack0       <= ~sel;
            ack1       <= sel;
            state      <= HOLD;
          end else if (cnt_value == '0) begin
            // An exhausted timer without done can only come from a corrupted load; recover.
            state <= IDLE;
          end
        end
        HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_sampler.sv
// tb/tb_mux2_sampler.sv - scoreboard bench for mux2_sampler driving a 2:1 mux model
module tb_mux2_sampler;

  logic clk = 1'b0;
  logic rst, req0, req1, ack0, ack1, sel, z, dout, dout_ch, dout_valid, dout_ready;
  logic d0, d1;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0] sb[$];
  logic       model_last;
  logic       g;

  always #5 clk = ~clk;

  assign z = sel ? d1 : d0;

  mux2_sampler #(
    .SETTLE_CYCLES(2),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .req1       (req1),
    .ack0       (ack0),
    .ack1       (ack1),
    .sel        (sel),
    .z          (z),
    .dout       (dout),
    .dout_ch    (dout_ch),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration decided from the request levels alone.
  task automatic predict_grant(output logic ch);
`ifdef MUX2_SAMPLER_RR_EN
    ch = (req0 && req1) ? ~model_last : req1;
`else
    ch = (req0 && req1) ? 1'b0 : req1;
`endif
    model_last = ch;
    sb.push_back({ch, ch ? d1 : d0});
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    chk("rst_sel", {7'd0, sel}, 8'd0);
    chk("rst_valid", {7'd0, dout_valid}, 8'd0);
    chk("rst_acks", {6'd0, ack1, ack0}, 8'd0);
    #2 rst = 1'b0;
    model_last = 1'b1;
  endtask

  // Capture-time scoreboard check plus ack exclusivity every cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("ack_excl", {7'd0, ack0 & ack1}, 8'd0);
      if (ack0 || ack1) begin
        logic [1:0] e;
        if (sb.size() == 0) begin
          chk("sb_unexpected", {7'd0, ack1}, 8'hff);
        end else begin
          e = sb.pop_front();
          chk("sb_ch", {7'd0, dout_ch}, {7'd0, e[1]});
          chk("sb_data", {7'd0, dout}, {7'd0, e[0]});
          chk("sb_ack1", {7'd0, ack1}, {7'd0, e[1]});
          chk("sb_valid", {7'd0, dout_valid}, 8'd1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; dout_ready = 1'b1; d0 = 1'b0; d1 = 1'b0;
    model_last = 1'b1;
    step();
    step();
    chk("reset_sel", {7'd0, sel}, 8'd0);
    chk("reset_dout", {6'd0, dout_ch, dout}, 8'd0);
    chk("reset_valid", {7'd0, dout_valid}, 8'd0);
    chk("reset_acks", {6'd0, ack1, ack0}, 8'd0);
    rst = 1'b0;

    // Single channel-0 request.
    d0 = 1'b1; d1 = 1'b0; req0 = 1'b1;
    predict_grant(g);
    step();
    chk("t1_sel", {7'd0, sel}, 8'd0);
    chk("t1_valid_early", {7'd0, dout_valid}, 8'd0);
    step();
    chk("t1_valid_settle", {7'd0, dout_valid}, 8'd0);
    step();
    chk("t1_ack0", {7'd0, ack0}, 8'd1);
    chk("t1_dout", {7'd0, dout}, 8'd1);
    req0 = 1'b0;
    step();
    chk("t1_ack0_width", {7'd0, ack0}, 8'd0);
    chk("t1_valid_drop", {7'd0, dout_valid}, 8'd0);

    // Both channels held high.
    pulse_rst();
    step();
    d0 = 1'b0; d1 = 1'b1; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      predict_grant(g);
      step();
      chk("t2_sel", {7'd0, sel}, {7'd0, g});
      step();
      step();
      chk("t2_ack0", {7'd0, ack0}, {7'd0, ~g});
      chk("t2_ack1", {7'd0, ack1}, {7'd0, g});
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      step();
      chk("t2_accept", {7'd0, dout_valid}, 8'd0);
    end
    step();
    chk("t2_idle", {7'd0, dout_valid | ack0 | ack1}, 8'd0);

    // Backpressure for five cycles.
    pulse_rst();
    step();
    d0 = 1'b1; d1 = 1'b0; req0 = 1'b1; dout_ready = 1'b0;
    predict_grant(g);
    step();
    step();
    step();
    chk("t3_capture", {7'd0, dout_valid}, 8'd1);
    req0 = 1'b0; d0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", {7'd0, dout_valid}, 8'd1);
      chk("t3_hold_dout", {7'd0, dout}, 8'd1);
      chk("t3_hold_sel", {7'd0, sel}, 8'd0);
    end
    dout_ready = 1'b1; req1 = 1'b1;
    step();
    chk("t3_accept", {7'd0, dout_valid}, 8'd0);
    chk("t3_no_early_grant", {7'd0, sel}, 8'd0);
    predict_grant(g);
    step();
    chk("t3_next_grant", {7'd0, sel}, 8'd1);
    step();
    step();
    chk("t3_ack1", {7'd0, ack1}, 8'd1);
    req1 = 1'b0;
    step();

    // Reset in the middle of settling.
    req1 = 1'b1;
    step();
    chk("t4_sel_pre", {7'd0, sel}, 8'd1);
    pulse_rst();
    chk("t4_sb_empty", 8'(sb.size()), 8'd0);
    req0 = 1'b1;
    predict_grant(g);
    step();
    chk("t4_tie_ch0", {7'd0, sel}, 8'd0);
    step();
    step();
    chk("t4_ack0", {7'd0, ack0}, 8'd1);
    req0 = 1'b0;
    step();
    predict_grant(g);
    step();
    chk("t4_req1_sel", {7'd0, sel}, 8'd1);
    step();
    step();
    req1 = 1'b0;
    step();

    // Short channel-1 pulse still completes.
    d1 = 1'b1; req1 = 1'b1;
    predict_grant(g);
    step();
    req1 = 1'b0;
    step();
    step();
    chk("t5_ack1", {7'd0, ack1}, 8'd1);
    chk("t5_dout_ch", {7'd0, dout_ch}, 8'd1);
    step();
    chk("t5_ack1_width", {7'd0, ack1}, 8'd0);
    step();
    step();
    chk("t5_no_regrant", {7'd0, ack0 | ack1 | dout_valid}, 8'd0);

    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
